// File: rtl/chimp_game_ctrl.sv
// Chimp-test game sequencer: LFSR tile placement on an 8x8 grid, ordered-click
// checking, level/strike/score tracking and a registered cell lookup for the renderer.
module chimp_game_ctrl #(
  parameter int          START_LEN   = 4,
  parameter int          MAX_LEN     = 16,
  parameter int          MAX_STRIKES = 3,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic       clk,
  input  logic       iReset,
  input  logic       iStart,
  input  logic       iClickValid,
  input  logic       iInBox,
  input  logic [2:0] iBoxX,
  input  logic [2:0] iBoxY,
  input  logic [2:0] iQueryX,
  input  logic [2:0] iQueryY,
  output logic [4:0] oQueryNum,
  output logic       oMasked,
  output logic [4:0] oLevel,
  output logic [2:0] oStrikes,
  output logic [4:0] oScore,
  output logic [2:0] oState,
  output logic       oDone
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PLACE = 3'd1,
    ST_SHOW  = 3'd2,
    ST_PLAY  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [4:0] START_L = 5'(START_LEN);
  localparam logic [4:0] MAX_L   = 5'(MAX_LEN);
  localparam logic [2:0] MAX_S   = 3'(MAX_STRIKES);

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [4:0]  cell_q [64];
  logic [4:0]  cell_d [64];
  logic [4:0]  level_q, level_d;
  logic [4:0]  score_q, score_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [4:0]  exp_q, exp_d;
  logic [4:0]  qnum_q, qnum_d;
  logic [2:0]  strikes_q, strikes_d;
  logic        masked_q, masked_d;
  logic        done_q, done_d;

  logic [5:0]  place_idx;
  logic [5:0]  click_idx;
  logic [4:0]  click_val;
  logic        click_hit;

  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    score_d   = score_q;
    cnt_d     = cnt_q;
    exp_d     = exp_q;
    strikes_d = strikes_q;
    masked_d  = masked_q;
    done_d    = done_q;
    cell_d    = cell_q;
    lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    // Query reads the pre-update map, so a same-cycle write returns the old value.
    qnum_d    = cell_q[{iQueryY, iQueryX}];
    place_idx = lfsr_q[5:0];
    click_idx = {iBoxY, iBoxX};
    click_val = cell_q[click_idx];
    click_hit = iClickValid & iInBox & (click_val != 5'd0);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (iStart) begin
          for (int i = 0; i < 64; i++) cell_d[i] = '0;
          level_d   = START_L;
          strikes_d = '0;
          score_d   = '0;
          masked_d  = 1'b0;
          done_d    = 1'b0;
          cnt_d     = 5'd1;
          state_d   = ST_PLACE;
        end
      end
      ST_PLACE: begin
        if (cell_q[place_idx] == 5'd0) begin
          cell_d[place_idx] = cnt_q;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == level_q) begin
            state_d  = ST_SHOW;
            exp_d    = 5'd1;
            masked_d = 1'b0;
          end
        end
      end
      ST_SHOW, ST_PLAY: begin
        if (click_hit) begin
          if (click_val == exp_q) begin
            cell_d[click_idx] = '0;
            exp_d    = exp_q + 5'd1;
            masked_d = 1'b1;
            state_d  = ST_PLAY;
            if (click_val == level_q) begin
              score_d = level_q;
              if (level_q == MAX_L) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
              end else begin
                for (int i = 0; i < 64; i++) cell_d[i] = '0;
                level_d  = level_q + 5'd1;
                cnt_d    = 5'd1;
                masked_d = 1'b0;
                state_d  = ST_PLACE;
              end
            end
          end else begin
            strikes_d = strikes_q + 3'd1;
            // On game over the layout stays so the display can reveal the answer.
            if (strikes_d == MAX_S) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              for (int i = 0; i < 64; i++) cell_d[i] = '0;
              cnt_d    = 5'd1;
              masked_d = 1'b0;
              state_d  = ST_PLACE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge iReset) begin
    if (!iReset) begin
      state_q   <= ST_IDLE;
      lfsr_q    <= LFSR_SEED;
      for (int i = 0; i < 64; i++) cell_q[i] <= '0;
      level_q   <= START_L;
      score_q   <= '0;
      cnt_q     <= 5'd1;
      exp_q     <= 5'd1;
      qnum_q    <= '0;
      strikes_q <= '0;
      masked_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      cell_q    <= cell_d;
      level_q   <= level_d;
      score_q   <= score_d;
      cnt_q     <= cnt_d;
      exp_q     <= exp_d;
      qnum_q    <= qnum_d;
      strikes_q <= strikes_d;
      masked_q  <= masked_d;
      done_q    <= done_d;
    end
  end

  assign oQueryNum = qnum_q;
  assign oMasked   = masked_q;
  assign oLevel    = level_q;
  assign oStrikes  = strikes_q;
  assign oScore    = score_q;
  assign oState    = state_q;
  assign oDone     = done_q;

endmodule
